// File: rtl/fp_mul_pkg.sv
// Shared types and FP32 bit patterns for the multiplier issue/collect stage.
package fp_mul_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      HOLD
   } issue_state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } fp_pair_t;

   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] FP32_PINF = 32'h7F80_0000;
   localparam logic [31:0] FP32_NINF = 32'hFF80_0000;
   localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/fp_operand_fifo.sv
// Small power-of-two FIFO of operand pairs; head is always visible on o_head.
module fp_operand_fifo
   import fp_mul_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  fp_pair_t               i_data,
   input  logic                   i_pop,
   output fp_pair_t               o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   fp_pair_t        r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic            w_push;
   logic            w_pop;

   assign o_full  = (r_count == FULL_COUNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // NOTE: payload storage has no reset; occupancy lives in the pointers, so stale words are never read.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // NOTE: non-blocking updates so pointers and count all see pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fp_mul_issue_ctrl.sv
// Issue/collect controller around the FP32 multiplier: queues operand pairs, issues one op at a
// time, captures the result on armed Ready or timeout, and presents results in order.
module fp_mul_issue_ctrl
   import fp_mul_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_a,
   input  logic [31:0]            in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_result,
   output logic                   out_nan,
   output logic                   out_timeout,
   output logic                   mul_en,
   output logic [31:0]            mul_a,
   output logic [31:0]            mul_b,
   input  logic [31:0]            mul_result,
   input  logic                   mul_ready,
   input  logic                   mul_nan,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] count
);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   issue_state_t  r_state;
   issue_state_t  w_next_state;
   logic [TW-1:0] r_timer;
   logic          r_arm;
   logic [31:0]   r_mul_a;
   logic [31:0]   r_mul_b;
   logic          r_out_valid;
   logic [31:0]   r_out_result;
   logic          r_out_nan;
   logic          r_out_timeout;
   logic          w_pop;
   logic          w_capture;
   logic          w_ready_hit;
   logic          w_full;
   logic          w_empty;
   fp_pair_t      w_head;
   fp_pair_t      w_in_pair;

   assign w_in_pair = '{a: in_a, b: in_b};

   fp_operand_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (in_valid && in_ready),
      .i_data  (w_in_pair),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (count)
   );

   assign in_ready    = !w_full;
   assign mul_en      = (r_state == ISSUE);
   assign busy        = (r_state != IDLE);
   assign mul_a       = r_mul_a;
   assign mul_b       = r_mul_b;
   assign out_valid   = r_out_valid;
   assign out_result  = r_out_result;
   assign out_nan     = r_out_nan;
   assign out_timeout = r_out_timeout;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      w_capture    = 1'b0;
      w_ready_hit  = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty && !r_out_valid) begin
               w_pop        = 1'b1;
               w_next_state = ISSUE;
            end
         end
         ISSUE: w_next_state = WAIT;
         WAIT: begin
            // Ready only counts once it has been seen low since issue, so a held level is not taken.
            w_ready_hit = r_arm && mul_ready;
            if (w_ready_hit || (r_timer == TIMER_LAST)) begin
               w_capture    = 1'b1;
               w_next_state = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_next_state = ISSUE;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_timer       <= '0;
         r_arm         <= 1'b0;
         r_mul_a       <= '0;
         r_mul_b       <= '0;
         r_out_valid   <= 1'b0;
         r_out_result  <= '0;
         r_out_nan     <= 1'b0;
         r_out_timeout <= 1'b0;
      end else begin
         if (w_pop) begin
            r_mul_a <= w_head.a;
            r_mul_b <= w_head.b;
            r_timer <= '0;
            r_arm   <= 1'b0;
         end else if (r_state == WAIT) begin
            r_timer <= r_timer + 1'b1;
            if (!mul_ready) r_arm <= 1'b1;
         end

         if (w_capture) begin
            r_out_result  <= mul_result;
            r_out_nan     <= mul_nan;
            r_out_timeout <= !w_ready_hit;
            r_out_valid   <= 1'b1;
         end else if ((r_state == HOLD) && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fp_mul_issue_ctrl.sv
// Bench for fp_mul_issue_ctrl: behavioural multiplier model, in-order result scoreboard,
// table-driven directed sequences and a randomized stream with backpressure.
module tb_fp_mul_issue_ctrl;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   in_valid, in_ready;
   logic [31:0]            in_a, in_b;
   logic                   out_valid, out_ready;
   logic [31:0]            out_result;
   logic                   out_nan, out_timeout;
   logic                   mul_en;
   logic [31:0]            mul_a, mul_b, mul_result;
   logic                   mul_ready, mul_nan;
   logic                   busy;
   logic [$clog2(DEPTH):0] count;

   always #5 clk = ~clk;

   fp_mul_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_nan(out_nan), .out_timeout(out_timeout),
      .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
      .mul_result(mul_result), .mul_ready(mul_ready), .mul_nan(mul_nan),
      .busy(busy), .count(count)
   );

   typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] res; logic nan; int n; bit never; } vec_t;
   typedef struct { logic [31:0] res; logic nan; logic to; } exp_t;
   typedef struct { logic [31:0] res; logic nan; int n; bit never; } mdl_t;

   vec_t        tbl [10];
   logic [63:0] op_q  [$];
   exp_t        exp_q [$];
   mdl_t        mdl_q [$];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void add(input vec_t v);
      op_q.push_back({v.a, v.b});
      exp_q.push_back('{v.res, v.nan, v.never});
      mdl_q.push_back('{v.res, v.nan, v.n, v.never});
   endfunction

   // Multiplier model: on En, present result/nan at once; Ready pulses after n low cycles, or never.
   bit model_auto = 1'b1;
   bit m_active   = 1'b0;
   bit m_never    = 1'b0;
   int m_cnt      = 0;
   initial begin
      mdl_t m;
      mul_ready = 1'b0; mul_result = '0; mul_nan = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (model_auto) begin
            if (mul_en) begin
               m = '{32'hDEAD_BEEF, 1'b0, 1, 1'b0};
               if (mdl_q.size() != 0) m = mdl_q.pop_front();
               mul_result = m.res; mul_nan = m.nan; m_cnt = m.n; m_never = m.never;
               m_active = 1'b1; mul_ready = 1'b0;
            end else if (m_active && !m_never) begin
               if (m_cnt > 0) begin m_cnt--; mul_ready = 1'b0; end
               else begin mul_ready = 1'b1; m_active = 1'b0; end
            end else begin
               mul_ready = 1'b0;
            end
         end
      end
   end

   // Scoreboard: issued operands in push order, En one cycle wide, operands held, results in order.
   logic [63:0] cur_op  = '0;
   bit          prev_en = 1'b0;
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset) begin
         if (mul_en) begin
            check("en_pulse_width", prev_en, 1'b0);
            if (op_q.size() == 0) check("issue_unexpected", mul_en, 1'b0);
            else begin cur_op = op_q.pop_front(); check("issue_operands", {mul_a, mul_b}, cur_op); end
         end else if (busy) begin
            check("operands_held", {mul_a, mul_b}, cur_op);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("result_unexpected", out_valid, 1'b0);
            else begin
               e = exp_q.pop_front();
               check("out_result", out_result, e.res);
               check("out_nan", out_nan, e.nan);
               check("out_timeout", out_timeout, e.to);
            end
         end
      end
      prev_en = mul_en;
   end

   task automatic push(input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1; in_a = a; in_b = b;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      check("push_accepted", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_en(input string name);
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (mul_en) break;
      end
      check({name, "_issued"}, mul_en, 1'b1);
   endtask

   task automatic wait_valid(input string name);
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      check({name, "_out_valid"}, out_valid, 1'b1);
   endtask

   task automatic drain(input string name);
      for (int t = 0; t < 4000; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy && !out_valid) break;
      end
      check({name, "_drained"}, {exp_q.size() == 0, busy, out_valid}, 3'b100);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   n;
      bit   rnd_done;
      tbl[0] = '{32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 5, 1'b0};
      tbl[1] = '{32'h40400000, 32'h40400000, 32'h41100000, 1'b0, 3, 1'b0};
      tbl[2] = '{32'h3FC00000, 32'h40200000, 32'h40700000, 1'b0, 4, 1'b0};
      tbl[3] = '{32'h40400000, 32'hBFA00000, 32'hC0700000, 1'b0, 2, 1'b0};
      tbl[4] = '{32'hC0000000, 32'h3F400000, 32'hBFC00000, 1'b0, 6, 1'b0};
      tbl[5] = '{32'hBFC00000, 32'hC0000000, 32'h40400000, 1'b0, 1, 1'b0};
      tbl[6] = '{32'h7FC00000, 32'h40000000, 32'h7FC00000, 1'b1, 0, 1'b1};
      tbl[7] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 3, 1'b0};
      tbl[8] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1, 2, 1'b0};
      tbl[9] = '{32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 7, 1'b0};

      in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_outs", {out_valid, out_nan, out_timeout, mul_en, busy}, '0);
      check("rst_data", {out_result, mul_a}, '0);
      check("rst_mul_b", mul_b, '0);
      check("rst_count", count, '0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      // Single op: issue latency and one-cycle En.
      add(tbl[0]);
      in_valid = 1'b1; in_a = tbl[0].a; in_b = tbl[0].b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk); check("t1_en_cycle_k1", mul_en, 1'b0); check("t1_count_k1", count, 1);
      @(negedge clk); check("t1_en_cycle_k2", mul_en, 1'b1);
      @(negedge clk); check("t1_en_cycle_k3", mul_en, 1'b0);
      drain("t1");

      // Result held under backpressure, then fill the FIFO behind it.
      out_ready = 1'b0;
      add(tbl[1]); push(tbl[1].a, tbl[1].b);
      wait_valid("t3");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t3_hold_flags", {out_valid, out_nan, mul_en, busy}, 4'b1001);
         check("t3_hold_result", out_result, tbl[1].res);
      end
      @(posedge clk); #1;
      for (int i = 2; i <= 5; i++) begin
         add(tbl[i]); push(tbl[i].a, tbl[i].b);
      end
      add(tbl[7]);
      in_valid = 1'b1; in_a = tbl[7].a; in_b = tbl[7].b;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_full_count", count, 4);
         check("t2_full_ready_en", {in_ready, mul_en, out_valid}, 3'b001);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      push(tbl[7].a, tbl[7].b);
      drain("t2");

      // Never-ready multiplier: forced capture after TIMEOUT wait cycles.
      add(tbl[6]); push(tbl[6].a, tbl[6].b);
      wait_en("t4");
      n = 0;
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      check("t4_wait_cycles", n, TIMEOUT + 1);
      drain("t4");

      // Table vectors with special values.
      for (int i = 8; i <= 9; i++) begin
         add(tbl[i]); push(tbl[i].a, tbl[i].b);
      end
      drain("tbl");

      // Ready held high from before issue must not be captured.
      model_auto = 1'b0;
      mul_ready = 1'b1; mul_result = 32'h1234_5678; mul_nan = 1'b1;
      op_q.push_back({32'h7F000000, 32'h40800000});
      exp_q.push_back('{32'h7F800000, 1'b0, 1'b0});
      push(32'h7F000000, 32'h40800000);
      wait_en("t5");
      @(posedge clk); #1;
      @(posedge clk); #1; mul_ready = 1'b0;
      @(negedge clk); check("t5_no_stale_capture", out_valid, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1; mul_ready = 1'b1; mul_result = 32'h7F800000; mul_nan = 1'b0;
      wait_valid("t5");
      @(posedge clk); #1; mul_ready = 1'b0;
      model_auto = 1'b1;
      drain("t5");

      // Reset while waiting with two ops queued.
      add(tbl[6]); push(tbl[6].a, tbl[6].b);
      add(tbl[0]); push(tbl[0].a, tbl[0].b);
      add(tbl[2]); push(tbl[2].a, tbl[2].b);
      repeat (5) @(negedge clk);
      check("t6_pre_count", count, 2);
      check("t6_pre_busy", busy, 1'b1);
      reset = 1'b0;
      #1;
      check("t6_rst_count", count, '0);
      check("t6_rst_flags", {in_ready, out_valid, mul_en, busy, out_nan, out_timeout}, 6'b100000);
      check("t6_rst_data", {mul_a, mul_b}, '0);
      check("t6_rst_result", out_result, '0);
      op_q.delete(); exp_q.delete(); mdl_q.delete();
      model_auto = 1'b0; m_active = 1'b0; mul_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1; mul_ready = 1'b1; mul_result = 32'hDEAD_BEEF;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t6_after_release", {out_valid, busy, mul_en}, 3'b000);
         if (i == 3) mul_ready = 1'b0;
      end
      @(posedge clk); #1;
      model_auto = 1'b1;

      // Randomized stream against the in-order scoreboard.
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               v.a = $urandom; v.b = $urandom; v.res = $urandom;
               v.nan = 1'($urandom_range(0, 1));
               v.n = $urandom_range(1, 12);
               v.never = ($urandom_range(0, 9) == 0);
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               add(v); push(v.a, v.b);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain("rand");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
